// File: rtl/bb_uart_rx.sv
// 8N1 UART receiver with a 16x oversample tick re-phased on every accepted start edge,
// 2-of-3 majority bit decisions and a ready/acknowledge handshake with overrun/framing flags.
module bb_uart_rx #(
  parameter int TICK_DIV   = 33,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rxack,
  output logic [7:0] rxdata,
  output logic       rxrdy,
  output logic       rxbsy,
  output logic       ovr,
  output logic       ferr
);

  localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [3:0]       TIB_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]       TIB_S0   = 4'd7;
  localparam logic [3:0]       TIB_S1   = 4'd8;
  localparam logic [3:0]       TIB_DEC  = 4'd9;
  localparam logic [3:0]       BIT_D7   = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             rxd_p0;
  logic             rxs;
  logic             rxs_d;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       tib;
  logic [3:0]       tib_nxt;
  logic [3:0]       bit_idx;
  logic             smp7;
  logic             smp8;
  logic [7:0]       shreg;

  logic             fall;
  logic             accept;
  logic             sample_en;
  logic             decide;
  logic             bit_val;
  logic             shift_en;
  logic             good_stop;
  logic             bad_stop;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Stage p0/p1: two-flop synchroniser, then previous-value flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_p0 <= 1'b1;
      rxs    <= 1'b1;
      rxs_d  <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxs    <= rxd_p0;
      rxs_d  <= rxs;
    end
  end

  assign fall    = ~rxs & rxs_d;
  assign tick    = (div_cnt == DIV_LAST);
  assign tib_nxt = tib + 4'd1;
  assign bit_val = maj3(smp7, smp8, rxs);
  assign rxbsy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // tib_nxt is the cumulative tick number within the bit, so tick k lands on tib_nxt == k mod 16
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sample_en = tick && (state != IDLE) && (state != BREAK);
    decide    = sample_en && (tib_nxt == TIB_DEC);
    shift_en  = 1'b0;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          accept    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (decide) state_nxt = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (decide) begin
          shift_en = 1'b1;
          if (bit_idx == BIT_D7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          good_stop = bit_val;
          bad_stop  = ~bit_val;
          state_nxt = bit_val ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p2: oversample timing, samples at ticks 7 and 8, majority completed with the live tick-9 value
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      tib     <= 4'd0;
      bit_idx <= 4'd0;
      smp7    <= 1'b1;
      smp8    <= 1'b1;
    end else if (accept) begin
      div_cnt <= '0;
      tib     <= 4'd0;
      bit_idx <= 4'd0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_ONE;
      if (sample_en) begin
        tib <= tib_nxt;
        if (tib == TIB_LAST) bit_idx <= bit_idx + 4'd1;
        if (tib_nxt == TIB_S0) smp7 <= rxs;
        if (tib_nxt == TIB_S1) smp8 <= rxs;
      end
    end
  end

  // Stage p3: byte assembly and consumer handshake; a good stop beats a simultaneous ack
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= 8'h00;
      rxdata <= 8'h00;
      rxrdy  <= 1'b0;
      ovr    <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      if (rxack) begin
        rxrdy <= 1'b0;
        ovr   <= 1'b0;
        ferr  <= 1'b0;
      end
      if (shift_en) shreg <= {bit_val, shreg[7:1]};
      if (good_stop) begin
        rxdata <= shreg;
        rxrdy  <= 1'b1;
        if (rxrdy && !rxack) ovr <= 1'b1;
      end
      if (bad_stop) ferr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bb_uart_rx.sv
// Randomised frame-level bench for bb_uart_rx; expected flags and data come from an
// abstract per-frame model of the handshake rules.
module tb_bb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rxack;
  logic [7:0] rxdata;
  logic       rxrdy;
  logic       rxbsy;
  logic       ovr;
  logic       ferr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_start = 0;
  int lat     = -1;
  int lat0    = 5052;
  logic rdy_d = 1'b0;
  event frame_start;

  logic [7:0] m_data;
  logic       m_rdy;
  logic       m_ovr;
  logic       m_ferr;

  bb_uart_rx dut (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .rxack (rxack),
    .rxdata(rxdata),
    .rxrdy (rxrdy),
    .rxbsy (rxbsy),
    .ovr   (ovr),
    .ferr  (ferr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rxrdy === 1'b1 && rdy_d !== 1'b1) lat = cyc - t_start;
    rdy_d = rxrdy;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: sim time %0t exceeded, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // Reference model: abstract effect of each receive event on the consumer-visible state
  task automatic model_reset();
    m_data = 8'h00; m_rdy = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic model_ack();
    m_rdy = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic model_good(input logic [7:0] b);
    if (m_rdy) m_ovr = 1'b1;
    m_rdy  = 1'b1;
    m_data = b;
  endtask

  task automatic model_bad();
    m_ferr = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rxdata"}, {24'd0, rxdata}, {24'd0, m_data});
    chk({tag, ".rxrdy"}, {31'd0, rxrdy}, {31'd0, m_rdy});
    chk({tag, ".ovr"}, {31'd0, ovr}, {31'd0, m_ovr});
    chk({tag, ".ferr"}, {31'd0, ferr}, {31'd0, m_ferr});
    chk({tag, ".rxbsy"}, {31'd0, rxbsy}, 32'd0);
  endtask

  task automatic do_ack();
    @(negedge clk) rxack = 1'b1;
    @(negedge clk) rxack = 1'b0;
    model_ack();
  endtask

  task automatic send_frame(input logic [7:0] b, input int per, input logic stop_v,
                            input int extra_low);
    @(negedge clk);
    rxd     = 1'b0;
    t_start = cyc;
    -> frame_start;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (per) @(negedge clk);
    end
    rxd = stop_v;
    repeat (per) @(negedge clk);
    if (extra_low > 0) begin
      rxd = 1'b0;
      repeat (extra_low) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    int         per;

    rst = 1'b1; rxd = 1'b1; rxack = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // good byte and latency from the start edge (2-flop sync + edge detect + 153 ticks)
    lat = -1;
    send_frame(8'h21, 521, 1'b1, 0);
    model_good(8'h21);
    check_outputs("good21");
    chk("good21.lat_in_window", {31'd0, (lat >= 5049 && lat <= 5055)}, 32'd1);
    if (lat >= 5049 && lat <= 5055) lat0 = lat;

    // glitch on idle line
    do_ack();
    @(negedge clk);
    rxd = 1'b0;
    repeat (100) @(negedge clk);
    chk("glitch.bsy_high", {31'd0, rxbsy}, 32'd1);
    repeat (50) @(negedge clk);
    rxd = 1'b1;
    repeat (170) @(negedge clk);
    check_outputs("glitch");
    send_frame(8'hA5, 521, 1'b1, 0);
    model_good(8'hA5);
    check_outputs("a5");

    // framing error, then a good frame while ferr stays sticky
    do_ack();
    send_frame(8'h5A, 521, 1'b0, 2 * 521);
    model_bad();
    check_outputs("frame5a");
    send_frame(8'h3C, 521, 1'b1, 0);
    model_good(8'h3C);
    check_outputs("frame3c");
    do_ack();
    @(negedge clk);
    check_outputs("frame_ack");

    // overrun
    send_frame(8'h11, 521, 1'b1, 0);
    model_good(8'h11);
    send_frame(8'h22, 521, 1'b1, 0);
    model_good(8'h22);
    check_outputs("overrun");
    do_ack();
    @(negedge clk);
    check_outputs("overrun_ack");

    // ack in exactly the stop-decision clk of a new byte
    b = 8'($urandom);
    send_frame(b, 521, 1'b1, 0);
    model_good(b);
    check_outputs("prior");
    fork
      send_frame(8'h77, 521, 1'b1, 0);
      begin
        @(frame_start);
        repeat (lat0 - 1) @(posedge clk);
        @(negedge clk) rxack = 1'b1;
        @(negedge clk) rxack = 1'b0;
      end
    join
    model_ack();
    model_good(8'h77);
    check_outputs("collision");

    // baud tolerance
    do_ack();
    lat = -1;
    send_frame(8'h55, 510, 1'b1, 0);
    model_good(8'h55);
    check_outputs("tol510");
    chk("tol510.lat_in_window", {31'd0, (lat >= 5049 && lat <= 5055)}, 32'd1);
    do_ack();
    send_frame(8'hAA, 531, 1'b1, 0);
    model_good(8'hAA);
    check_outputs("tol531");

    for (int k = 0; k < 2; k++) begin
      b   = 8'($urandom);
      per = int'($urandom_range(510, 531));
      if ($urandom_range(0, 1) == 1) do_ack();
      send_frame(b, per, 1'b1, 0);
      model_good(b);
      check_outputs($sformatf("rand%0d", k));
    end

    // reset in the middle of data bit 2 of 0xFF; the rest of the frame must be ignored
    fork
      send_frame(8'hFF, 521, 1'b1, 0);
      begin
        @(frame_start);
        repeat (3 * 521 + 260) @(negedge clk);
        chk("midreset.bsy_before", {31'd0, rxbsy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check_outputs("midreset");
        rst = 1'b0;
      end
    join
    check_outputs("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
